// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: key conditioning, 100 Hz tick extraction and start/stop/lap/reset FSM.
// Latency: press event 2+DEBOUNCE_CYCLES cycles after a steady key edge, FSM outputs one cycle later; cnt_en 2 cycles after tb_100Hz is sampled high.
// No backpressure: every output is a registered pulse or level that the time counter and display consume unconditionally.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk_50MHz,
  input  logic       rst,
  input  logic       btn_start_stop_raw,
  input  logic       btn_lap_reset_raw,
  input  logic       tb_100Hz,
  input  logic       cnt_overflow,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       lap_latch,
  output logic       disp_hold,
  output logic [1:0] state,
  output logic       running
);

  localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  // raw level of a released key, per key
  localparam logic [1:0]    RAW_IDLE = BTN_ACTIVE_LOW ? 2'b11 : 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  // bit 0 = start/stop key, bit 1 = lap/reset key
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    pressed;
  logic [1:0]    stable;
  logic [1:0]    stable_d;
  logic [1:0]    press;
  logic [CW-1:0] db_cnt [2];

  logic          tb_q;
  logic          tb_prev;
  logic          tick;

  state_t        cur_state;
  state_t        nxt_state;
  logic          clr_nxt;
  logic          latch_nxt;

  assign raw     = {btn_lap_reset_raw, btn_start_stop_raw};
  // after normalisation 1 always means "pressed"
  assign pressed = sync2 ^ RAW_IDLE;
  assign press   = stable & ~stable_d;

  // two-flop synchroniser for the asynchronous keys
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      sync1 <= RAW_IDLE;
      sync2 <= RAW_IDLE;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      stable   <= 2'b00;
      stable_d <= 2'b00;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      stable_d <= stable;
      for (int i = 0; i < 2; i++) begin
        if (pressed[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          stable[i] <= pressed[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // timebase rising-edge detect, registered so the tick lines up with the FSM inputs
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      tb_q    <= 1'b0;
      tb_prev <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tb_q    <= tb_100Hz;
      tb_prev <= tb_q;
      tick    <= tb_q & ~tb_prev;
    end
  end

  // state register
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) cur_state <= IDLE;
    else     cur_state <= nxt_state;
  end

  // next state and control pulses; overflow first, then start/stop, then lap/reset
  always_comb begin
    nxt_state = cur_state;
    clr_nxt   = 1'b0;
    latch_nxt = 1'b0;
    case (cur_state)
      IDLE: begin
        if (press[0])      nxt_state = RUN;
        else if (press[1]) clr_nxt   = 1'b1;
      end
      RUN: begin
        if (cnt_overflow || press[0]) begin
          nxt_state = PAUSE;
        end else if (press[1]) begin
          nxt_state = LAP;
          latch_nxt = 1'b1;
        end
      end
      LAP: begin
        if (cnt_overflow || press[0]) nxt_state = PAUSE;
        else if (press[1])            nxt_state = RUN;
      end
      PAUSE: begin
        if (press[0]) begin
          // a full counter cannot be restarted; the event is dropped
          if (!cnt_overflow) nxt_state = RUN;
        end else if (press[1]) begin
          nxt_state = IDLE;
          clr_nxt   = 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // registered outputs; cnt_en uses the pre-transition state so a stop still gets its tick
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      cnt_en    <= 1'b0;
      cnt_clr   <= 1'b0;
      lap_latch <= 1'b0;
      disp_hold <= 1'b0;
      running   <= 1'b0;
    end else begin
      cnt_en    <= tick && ((cur_state == RUN) || (cur_state == LAP));
      cnt_clr   <= clr_nxt;
      lap_latch <= latch_nxt;
      disp_hold <= (nxt_state == LAP);
      running   <= (nxt_state == RUN) || (nxt_state == LAP);
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4: directed corner sequences, a vector table
// of key actions, and a randomized run checked against a history-based reference model.
module tb_stopwatch_ctrl;

  localparam int D  = 4;
  localparam int NR = 2000;

  logic       clk_50MHz = 1'b0;
  logic       rst;
  logic       btn_start_stop_raw;
  logic       btn_lap_reset_raw;
  logic       tb_100Hz;
  logic       cnt_overflow;
  logic       cnt_en;
  logic       cnt_clr;
  logic       lap_latch;
  logic       disp_hold;
  logic [1:0] state;
  logic       running;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(D), .BTN_ACTIVE_LOW(1'b1)) dut (
    .clk_50MHz          (clk_50MHz),
    .rst                (rst),
    .btn_start_stop_raw (btn_start_stop_raw),
    .btn_lap_reset_raw  (btn_lap_reset_raw),
    .tb_100Hz           (tb_100Hz),
    .cnt_overflow       (cnt_overflow),
    .cnt_en             (cnt_en),
    .cnt_clr            (cnt_clr),
    .lap_latch          (lap_latch),
    .disp_hold          (disp_hold),
    .state              (state),
    .running            (running)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    bit         ss;
    bit         lr;
    bit         ovf;
    int         hold;
    logic [1:0] st;
    int         clr;
    int         latch;
  } vec_t;

  localparam int NV = 20;
  vec_t vt [NV];

  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_LAP} mode_t;

  // reference model: key/timebase history plus abstract mode
  bit    key_h [2][NR];
  bit    tb_h  [NR];
  bit    m_stable [2];
  bit    m_rose   [2];
  mode_t m_mode;

  int cnt_seen, pos1, pos2, clr_seen, latch_seen;
  bit ss_lvl, lr_lvl, tb_lvl, ovf_lvl;
  int ss_rem, lr_rem, tb_rem, ovf_rem;
  logic [6:0] expv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  task automatic step();
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic set_keys(input bit ss, input bit lr);
    btn_start_stop_raw = ~ss;
    btn_lap_reset_raw  = ~lr;
  endtask

  task automatic press_key(input bit ss, input bit lr);
    set_keys(ss, lr);
    repeat (10) step();
    set_keys(1'b0, 1'b0);
    repeat (10) step();
  endtask

  function automatic logic [6:0] outs();
    return {state, running, disp_hold, cnt_en, cnt_clr, lap_latch};
  endfunction

  function automatic bit key_at(input int k, input int i);
    if (i < 0) return 1'b0;
    return key_h[k][i];
  endfunction

  function automatic bit tb_at(input int i);
    if (i < 0) return 1'b0;
    return tb_h[i];
  endfunction

  // expected outputs after clock edge n (edges counted from reset release)
  task automatic model_edge(input int n, input bit ovf, output logic [6:0] req);
    bit p_ss, p_lr, all_diff, counting, en, clr, latch;
    logic [1:0] code;
    p_ss = m_rose[0];
    p_lr = m_rose[1];
    // a key level is accepted once its last D synchronised samples all oppose the old level
    for (int k = 0; k < 2; k++) begin
      all_diff = 1'b1;
      for (int j = 0; j < D; j++) begin
        if (n - j < 0) all_diff = 1'b0;
        else if (key_at(k, n - j - 2) == m_stable[k]) all_diff = 1'b0;
      end
      m_rose[k] = all_diff && !m_stable[k];
      if (all_diff) m_stable[k] = !m_stable[k];
    end
    counting = (m_mode == M_RUN) || (m_mode == M_LAP);
    en    = counting && tb_at(n - 2) && !tb_at(n - 3);
    clr   = 1'b0;
    latch = 1'b0;
    if (ovf && counting) begin
      m_mode = M_PAUSE;
    end else if (p_ss) begin
      if (m_mode == M_IDLE) m_mode = M_RUN;
      else if (m_mode == M_PAUSE) begin
        if (!ovf) m_mode = M_RUN;
      end else m_mode = M_PAUSE;
    end else if (p_lr) begin
      case (m_mode)
        M_IDLE:  clr = 1'b1;
        M_RUN:   begin m_mode = M_LAP; latch = 1'b1; end
        M_LAP:   m_mode = M_RUN;
        default: begin m_mode = M_IDLE; clr = 1'b1; end
      endcase
    end
    case (m_mode)
      M_IDLE:  code = 2'b00;
      M_RUN:   code = 2'b01;
      M_PAUSE: code = 2'b10;
      default: code = 2'b11;
    endcase
    req = {code, (m_mode == M_RUN) || (m_mode == M_LAP), m_mode == M_LAP, en, clr, latch};
  endtask

  task automatic tick_window(input string tag);
    cnt_seen = 0; pos1 = -1; pos2 = -1;
    for (int i = 0; i < 80; i++) begin
      tb_100Hz = ((i / 20) % 2 == 1);
      step();
      if (cnt_en) begin
        cnt_seen++;
        if (pos1 < 0) pos1 = i;
        else pos2 = i;
      end
    end
    tb_100Hz = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    //            ss    lr    ovf   hold st     clr latch
    vt[0]  = '{1'b0, 1'b1, 1'b0, 8, 2'b00, 1, 0};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 8, 2'b01, 0, 0};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 8, 2'b11, 0, 1};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 8, 2'b01, 0, 0};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 3, 2'b01, 0, 0};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 8, 2'b10, 0, 0};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 3, 2'b10, 0, 0};
    vt[7]  = '{1'b1, 1'b0, 1'b1, 8, 2'b10, 0, 0};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 8, 2'b01, 0, 0};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 8, 2'b10, 0, 0};
    vt[10] = '{1'b1, 1'b0, 1'b0, 8, 2'b01, 0, 0};
    vt[11] = '{1'b1, 1'b1, 1'b0, 8, 2'b10, 0, 0};
    vt[12] = '{1'b0, 1'b1, 1'b0, 8, 2'b00, 1, 0};
    vt[13] = '{1'b1, 1'b0, 1'b0, 8, 2'b01, 0, 0};
    vt[14] = '{1'b0, 1'b1, 1'b0, 8, 2'b11, 0, 1};
    vt[15] = '{1'b1, 1'b1, 1'b0, 8, 2'b10, 0, 0};
    vt[16] = '{1'b1, 1'b0, 1'b0, 8, 2'b01, 0, 0};
    vt[17] = '{1'b0, 1'b1, 1'b0, 8, 2'b11, 0, 1};
    vt[18] = '{1'b0, 1'b0, 1'b1, 8, 2'b10, 0, 0};
    vt[19] = '{1'b0, 1'b1, 1'b0, 8, 2'b00, 1, 0};

    rst = 1'b1;
    set_keys(1'b0, 1'b0);
    tb_100Hz     = 1'b0;
    cnt_overflow = 1'b0;
    repeat (3) step();
    check("reset_outputs", outs(), 7'b0);

    // press latency: state changes exactly 7 edges after the raw edge
    rst = 1'b0;
    set_keys(1'b1, 1'b0);
    repeat (6) step();
    check("latency_state_edge6", state, 2'b00);
    step();
    check("latency_state_edge7", state, 2'b01);
    check("latency_running_edge7", running, 1'b1);
    repeat (3) step();
    set_keys(1'b0, 1'b0);
    repeat (10) step();
    press_key(1'b1, 1'b0);
    check("second_press_pause", state, 2'b10);
    press_key(1'b1, 1'b0);
    check("restart_run", state, 2'b01);

    // tick latency: cnt_en on the second edge after the one that samples tb_100Hz high
    tb_100Hz = 1'b1;
    step();
    step();
    check("tick_edge2_low", cnt_en, 1'b0);
    step();
    check("tick_edge3_high", cnt_en, 1'b1);
    step();
    check("tick_edge4_low", cnt_en, 1'b0);
    tb_100Hz = 1'b0;
    repeat (5) step();

    tick_window("run");
    check("run_tick_count", cnt_seen, 2);
    check("run_tick_pos1", pos1, 22);
    check("run_tick_pos2", pos2, 62);

    press_key(1'b1, 1'b0);
    check("pause_state", state, 2'b10);
    tick_window("pause");
    check("pause_tick_count", cnt_seen, 0);

    press_key(1'b1, 1'b0);
    press_key(1'b0, 1'b1);
    check("lap_state", state, 2'b11);
    check("lap_disp_hold", disp_hold, 1'b1);
    tick_window("lap");
    check("lap_tick_count", cnt_seen, 2);
    press_key(1'b0, 1'b1);
    check("lap_exit_state", state, 2'b01);
    check("lap_exit_disp_hold", disp_hold, 1'b0);

    // overflow acts on the next edge and blocks a restart
    cnt_overflow = 1'b1;
    step();
    check("ovf_next_edge", state, 2'b10);
    press_key(1'b1, 1'b0);
    check("ovf_start_dropped", state, 2'b10);
    cnt_overflow = 1'b0;
    step();

    // asynchronous reset in LAP, observed before any further clock edge
    press_key(1'b1, 1'b0);
    press_key(1'b0, 1'b1);
    check("pre_reset_lap", state, 2'b11);
    #3;
    rst = 1'b1;
    #1;
    check("reset_midlap_outputs", outs(), 7'b0);
    repeat (2) step();
    rst = 1'b0;
    repeat (2) step();

    // vector table of key actions starting from IDLE
    for (int r = 0; r < NV; r++) begin
      clr_seen   = 0;
      latch_seen = 0;
      set_keys(vt[r].ss, vt[r].lr);
      cnt_overflow = vt[r].ovf;
      for (int c = 0; c < 16; c++) begin
        if (c == vt[r].hold) set_keys(1'b0, 1'b0);
        step();
        clr_seen   += int'(cnt_clr);
        latch_seen += int'(lap_latch);
      end
      cnt_overflow = 1'b0;
      repeat (2) step();
      check($sformatf("vec%0d_state", r), state, vt[r].st);
      check($sformatf("vec%0d_disp_hold", r), disp_hold, (vt[r].st == 2'b11));
      check($sformatf("vec%0d_clr_pulses", r), clr_seen, vt[r].clr);
      check($sformatf("vec%0d_latch_pulses", r), latch_seen, vt[r].latch);
    end

    // randomized run against the reference model
    rst = 1'b1;
    set_keys(1'b0, 1'b0);
    tb_100Hz     = 1'b0;
    cnt_overflow = 1'b0;
    repeat (2) step();
    for (int k = 0; k < 2; k++) begin
      m_stable[k] = 1'b0;
      m_rose[k]   = 1'b0;
    end
    m_mode = M_IDLE;
    ss_lvl = 0; lr_lvl = 0; tb_lvl = 0; ovf_lvl = 0;
    ss_rem = 0; lr_rem = 0; tb_rem = 3; ovf_rem = 0;
    rst = 1'b0;
    for (int n = 0; n < NR; n++) begin
      if (ss_rem == 0) begin
        ss_lvl = ($urandom_range(0, 99) < 35);
        ss_rem = $urandom_range(1, 12);
      end
      if (lr_rem == 0) begin
        lr_lvl = ($urandom_range(0, 99) < 35);
        lr_rem = $urandom_range(1, 12);
      end
      if (tb_rem == 0) begin
        tb_lvl = !tb_lvl;
        tb_rem = $urandom_range(2, 9);
      end
      if (ovf_rem == 0) begin
        ovf_lvl = ($urandom_range(0, 99) < 8);
        ovf_rem = $urandom_range(1, 5);
      end
      ss_rem--; lr_rem--; tb_rem--; ovf_rem--;
      key_h[0][n] = ss_lvl;
      key_h[1][n] = lr_lvl;
      tb_h[n]     = tb_lvl;
      set_keys(ss_lvl, lr_lvl);
      tb_100Hz     = tb_lvl;
      cnt_overflow = ovf_lvl;
      step();
      model_edge(n, ovf_lvl, expv);
      check($sformatf("rand_cycle%0d", n), outs(), expv);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
